bus_source_arbiter: RTL and testbench

//  Round-robin arbiter for the shared 32-bit CPU bus. Accepts one request per bus source and

---
 rtl/bus_pkg.sv | 35 +++
 rtl/rr_pick.sv | 34 +++
 rtl/bus_source_arbiter.sv | 99 +++++++++
 tb/tb_bus_source_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared bus definitions: source count, select width, source index map and arbiter states.
package bus_pkg;

  localparam int NUM_BUS_SRC = 24;
  localparam int BUS_SEL_W   = 5;

  // Bus source indices; bit i of every request/grant vector is source i.
  localparam int SRC_C      = 0;
  localparam int SRC_INPORT = 1;
  localparam int SRC_MDR    = 2;
  localparam int SRC_PC     = 3;
  localparam int SRC_ZLO    = 4;
  localparam int SRC_ZHI    = 5;
  localparam int SRC_LO     = 6;
  localparam int SRC_HI     = 7;
  localparam int SRC_R15    = 8;
  localparam int SRC_R14    = 9;
  localparam int SRC_R13    = 10;
  localparam int SRC_R12    = 11;
  localparam int SRC_R11    = 12;
  localparam int SRC_R10    = 13;
  localparam int SRC_R9     = 14;
  localparam int SRC_R8     = 15;
  localparam int SRC_R7     = 16;
  localparam int SRC_R6     = 17;
  localparam int SRC_R5     = 18;
  localparam int SRC_R4     = 19;
  localparam int SRC_R3     = 20;
  localparam int SRC_R2     = 21;
  localparam int SRC_R1     = 22;
  localparam int SRC_R0     = 23;

  typedef enum logic {IDLE, OWN} arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set request at or after start_idx, with wrap.
module rr_pick #(
  parameter int NUM_SRC = 24,
  parameter int SEL_W   = 5
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SEL_W-1:0]   start_idx,
  output logic               found,
  output logic [SEL_W-1:0]   win_idx,
  output logic [NUM_SRC-1:0] win_onehot
);

  int               idx;
  logic [SEL_W-1:0] idx_s;

  always_comb begin
    found      = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    idx        = 0;
    idx_s      = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = int'(start_idx) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      idx_s = SEL_W'(idx);
      if (!found && req[idx_s]) begin
        found             = 1'b1;
        win_idx           = idx_s;
        win_onehot[idx_s] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_source_arbiter.sv
// Round-robin bus source arbiter with lock-based multi-cycle ownership bounded by a hold timeout.
module bus_source_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_SRC  = NUM_BUS_SRC,
  parameter int SEL_W    = BUS_SEL_W,
  parameter int MAX_HOLD = 15
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic [NUM_SRC-1:0] req,
  input  logic [NUM_SRC-1:0] lock,
  output logic [NUM_SRC-1:0] grant,
  output logic [SEL_W-1:0]   bus_sel,
  output logic               bus_valid,
  output logic               hold_timeout
);

  localparam int               HOLD_W   = $clog2(MAX_HOLD + 1);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_SRC - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  arb_state_t          state_q, state_d;
  logic [SEL_W-1:0]    owner_q, owner_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [NUM_SRC-1:0]  grant_q, grant_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                tmo_q, tmo_d;

  logic [SEL_W-1:0]    start_idx;
  logic                found;
  logic [SEL_W-1:0]    win_idx;
  logic [NUM_SRC-1:0]  win_onehot;
  logic                owner_locked;

  // Search always begins just past the last owner, which IDLE preserves.
  assign start_idx    = (owner_q == LAST_IDX) ? '0 : owner_q + SEL_W'(1);
  assign owner_locked = req[owner_q] & lock[owner_q];

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_pick (
    .req        (req),
    .start_idx  (start_idx),
    .found      (found),
    .win_idx    (win_idx),
    .win_onehot (win_onehot)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    grant_d = '0;
    sel_d   = '0;
    tmo_d   = 1'b0;
    if (state_q == OWN && owner_locked && hold_q < HOLD_MAX) begin
      grant_d = grant_q;
      sel_d   = sel_q;
      hold_d  = hold_q + HOLD_W'(1);
    end else begin
      tmo_d = (state_q == OWN) && owner_locked;
      if (found) begin
        state_d = OWN;
        owner_d = win_idx;
        hold_d  = HOLD_W'(1);
        grant_d = win_onehot;
        sel_d   = win_idx;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      owner_q <= LAST_IDX;
      hold_q  <= '0;
      grant_q <= '0;
      sel_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      tmo_q   <= tmo_d;
    end
  end

  assign grant        = grant_q;
  assign bus_sel      = sel_q;
  assign bus_valid    = |grant_q;
  assign hold_timeout = tmo_q;

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Scoreboard bench for bus_source_arbiter: directed scenarios plus randomized bursts vs a reference model.
module tb_bus_source_arbiter;
  import bus_pkg::*;

  localparam int N  = 24;
  localparam int SW = 5;
  localparam int MH = 15;

  logic          clk = 1'b0;
  logic          clr_n;
  logic [N-1:0]  req;
  logic [N-1:0]  lock;
  logic [N-1:0]  grant;
  logic [SW-1:0] bus_sel;
  logic          bus_valid;
  logic          hold_timeout;

  typedef struct {
    logic [N-1:0]  g;
    logic [SW-1:0] s;
    logic          v;
    logic          t;
    int            tag;
  } exp_t;

  typedef struct {
    int tag;
    int sel;
    int tmo;
  } log_t;

  exp_t sbq[$];
  log_t log_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference model: owner index (-1 when idle), last granted index, cycles held.
  int m_owner;
  int m_last;
  int m_held;

  bus_source_arbiter #(.NUM_SRC(N), .SEL_W(SW), .MAX_HOLD(MH)) dut (
    .clk          (clk),
    .clr_n        (clr_n),
    .req          (req),
    .lock         (lock),
    .grant        (grant),
    .bus_sel      (bus_sel),
    .bus_valid    (bus_valid),
    .hold_timeout (hold_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_held  = 0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] l, input int tag);
    exp_t e;
    int   w;
    int   idx;
    logic t;
    t = 1'b0;
    if (m_owner >= 0 && r[m_owner[4:0]] && l[m_owner[4:0]] && m_held < MH) begin
      m_held++;
    end else begin
      t = (m_owner >= 0) && r[m_owner[4:0]] && l[m_owner[4:0]];
      w = -1;
      for (int k = 1; k <= N; k++) begin
        idx = (m_last + k) % N;
        if (w < 0 && r[idx[4:0]]) w = idx;
      end
      if (w >= 0) begin
        m_owner = w;
        m_last  = w;
        m_held  = 1;
      end else begin
        m_owner = -1;
      end
    end
    e.g   = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    e.s   = (m_owner >= 0) ? SW'(m_owner) : '0;
    e.v   = (m_owner >= 0);
    e.t   = t;
    e.tag = tag;
    sbq.push_back(e);
  endtask

  task automatic step(input logic [N-1:0] r, input logic [N-1:0] l, input int tag);
    @(posedge clk);
    #2;
    req  = r;
    lock = l;
    model_step(r, l, tag);
  endtask

  task automatic release_step(input logic [N-1:0] r, input logic [N-1:0] l, input int tag);
    @(posedge clk);
    #2;
    clr_n = 1'b1;
    req   = r;
    lock  = l;
    model_step(r, l, tag);
  endtask

  task automatic check_idle_outputs(input string pfx);
    chk({pfx, "_grant"}, 32'(grant), 32'h0);
    chk({pfx, "_sel"}, 32'(bus_sel), 32'h0);
    chk({pfx, "_valid"}, 32'(bus_valid), 32'h0);
    chk({pfx, "_tmo"}, 32'(hold_timeout), 32'h0);
  endtask

  task automatic verify(input int tag, input int exp_sel[$], input int tmo_idx);
    int got[$];
    int gtmo[$];
    foreach (log_q[i]) begin
      if (log_q[i].tag == tag) begin
        got.push_back(log_q[i].sel);
        gtmo.push_back(log_q[i].tmo);
      end
    end
    chk($sformatf("t%0d_len", tag), 32'(got.size()), 32'(exp_sel.size()));
    for (int i = 0; i < exp_sel.size() && i < got.size(); i++) begin
      chk($sformatf("t%0d_sel[%0d]", tag, i), 32'(got[i]), 32'(exp_sel[i]));
      chk($sformatf("t%0d_tmo[%0d]", tag, i), 32'(gtmo[i]), (i == tmo_idx) ? 32'h1 : 32'h0);
    end
  endtask

  // Monitor: compares every registered output against the scoreboard head.
  always @(posedge clk) begin
    #1;
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      chk("grant", 32'(grant), 32'(mon_e.g));
      chk("bus_sel", 32'(bus_sel), 32'(mon_e.s));
      chk("bus_valid", 32'(bus_valid), 32'(mon_e.v));
      chk("hold_timeout", 32'(hold_timeout), 32'(mon_e.t));
      chk("onehot0", 32'($onehot0(grant)), 32'h1);
      log_q.push_back('{mon_e.tag, int'(bus_sel), int'(hold_timeout)});
    end
  end

  initial begin
    int            e[$];
    logic [N-1:0]  r;
    logic [N-1:0]  l;
    int            len;

    clr_n = 1'b0;
    req   = '1;
    lock  = '0;
    model_reset();

    // Reset held with every source requesting
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    release_step('1, '0, 1);

    // Unlocked rotation among PC, R15, R0
    r = '0;
    r[SRC_PC] = 1'b1; r[SRC_R15] = 1'b1; r[SRC_R0] = 1'b1;
    repeat (6) step(r, '0, 2);

    // Locked owner with one competitor: timeout after MAX_HOLD cycles
    r = '0; l = '0;
    r[SRC_MDR] = 1'b1; r[SRC_ZHI] = 1'b1; l[SRC_MDR] = 1'b1;
    repeat (17) step(r, l, 3);

    // Early release of a locked owner, then idle
    r = '0; l = '0;
    r[7] = 1'b1; r[12] = 1'b1; l[7] = 1'b1;
    repeat (4) step(r, l, 4);
    r = '0; r[12] = 1'b1;
    step(r, '0, 4);
    step('0, '0, 4);

    // Wrap from last owner 23
    r = '0; r[23] = 1'b1;
    step(r, '0, 5);
    r = '0; r[0] = 1'b1; r[22] = 1'b1;
    repeat (2) step(r, '0, 5);

    // Async reset in the middle of a locked ownership
    r = '0; l = '0;
    r[3] = 1'b1; l[3] = 1'b1;
    repeat (5) step(r, l, 6);
    @(posedge clk);
    #3;
    clr_n = 1'b0;
    sbq.delete();
    model_reset();
    #1;
    check_idle_outputs("async_rst");
    r = '0; r[2] = 1'b1; r[23] = 1'b1;
    release_step(r, '0, 8);

    // Randomized bursts with steady req/lock so timeouts occur
    for (int b = 0; b < 25; b++) begin
      r   = N'($urandom) & N'($urandom);
      l   = N'($urandom) & N'($urandom);
      len = $urandom_range(1, 20);
      for (int c = 0; c < len; c++) step(r, l, 7);
    end
    step('0, '0, 0);
    step('0, '0, 0);

    e = '{0};
    verify(1, e, -1);
    e = '{3, 8, 23, 3, 8, 23};
    verify(2, e, -1);
    e.delete();
    for (int i = 0; i < 15; i++) e.push_back(2);
    e.push_back(5);
    e.push_back(2);
    verify(3, e, 15);
    e = '{7, 7, 7, 7, 12, 0};
    verify(4, e, -1);
    e = '{23, 0, 22};
    verify(5, e, -1);
    e = '{3, 3, 3, 3, 3};
    verify(6, e, -1);
    e = '{2};
    verify(8, e, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
